vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blank timing with a lead-ahead pixel request and built-in test patterns.
module vga_timing_gen #(
    parameter int COLOR_W  = 10,
    parameter int H_SYNC_W = 96,
    parameter int H_BP     = 48,
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC_W = 2,
    parameter int V_BP     = 33,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int REQ_LEAD = 2
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    input  logic [1:0]         iMODE,
    output logic               oRequest,
    output logic [10:0]        oX,
    output logic [10:0]        oY,
    output logic               oLineStart,
    output logic               oFrameStart,
    output logic [15:0]        oFrameCount,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK_N,
    output logic               oVGA_SYNC
);
    localparam logic [11:0] hLast   = 12'(H_SYNC_W + H_BP + H_ACT + H_FP - 1);
    localparam logic [11:0] vLast   = 12'(V_SYNC_W + V_BP + V_ACT + V_FP - 1);
    localparam logic [11:0] hSyncW  = 12'(H_SYNC_W);
    localparam logic [11:0] vSyncW  = 12'(V_SYNC_W);
    localparam logic [11:0] xStart  = 12'(H_SYNC_W + H_BP);
    localparam logic [11:0] xEnd    = 12'(H_SYNC_W + H_BP + H_ACT);
    localparam logic [11:0] yStart  = 12'(V_SYNC_W + V_BP);
    localparam logic [11:0] yEnd    = 12'(V_SYNC_W + V_BP + V_ACT);
    localparam logic [11:0] rqStart = 12'(H_SYNC_W + H_BP - REQ_LEAD);
    localparam logic [11:0] rqEnd   = 12'(H_SYNC_W + H_BP + H_ACT - REQ_LEAD);

    if (H_SYNC_W + H_BP < REQ_LEAD || REQ_LEAD < 0 || REQ_LEAD > 4) begin : gBadLead
        $error("vga_timing_gen: REQ_LEAD must be 0..4 and not exceed H_SYNC_W+H_BP");
    end

    logic [11:0]        h, v, hNext, vNext;
    logic [10:0]        xa, ya;
    logic [1:0]         mode;
    logic [2:0]         barCode;
    logic               active, grid, origin, seenFrame;
    logic [COLOR_W-1:0] pixR, pixG, pixB;

    always_comb begin
        hNext   = (h == hLast) ? '0 : h + 12'd1;
        vNext   = (h == hLast) ? ((v == vLast) ? '0 : v + 12'd1) : v;
        origin  = (h == '0) && (v == '0);
        active  = (h >= xStart) && (h < xEnd) && (v >= yStart) && (v < yEnd);
        xa      = 11'(h - xStart);
        ya      = 11'(v - yStart);
        barCode = 3'd7 - 3'(32'(xa) * 32'd8 / 32'(H_ACT));
        grid    = (xa[3:0] == 4'd0) || (ya[3:0] == 4'd0);
        pixR    = (mode == 2'd0) ? iRed   : (mode == 2'd1) ? {COLOR_W{barCode[2]}} : (mode == 2'd2) ? {COLOR_W{grid}} : '0;
        pixG    = (mode == 2'd0) ? iGreen : (mode == 2'd1) ? {COLOR_W{barCode[1]}} : (mode == 2'd2) ? {COLOR_W{grid}} : '0;
        pixB    = (mode == 2'd0) ? iBlue  : (mode == 2'd1) ? {COLOR_W{barCode[0]}} : (mode == 2'd2) ? {COLOR_W{grid}} : '0;
    end

    assign oVGA_SYNC = 1'b0;

    // Request is registered from the next counter values so it is high during the counter cycles it names.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            h            <= '0;
            v            <= '0;
            mode         <= '0;
            seenFrame    <= 1'b0;
            oRequest     <= 1'b0;
            oX           <= '0;
            oY           <= '0;
            oLineStart   <= 1'b0;
            oFrameStart  <= 1'b0;
            oFrameCount  <= '0;
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_H_SYNC  <= ~H_POL;
            oVGA_V_SYNC  <= ~V_POL;
            oVGA_BLANK_N <= 1'b0;
        end else begin
            h            <= hNext;
            v            <= vNext;
            oRequest     <= (hNext >= rqStart) && (hNext < rqEnd) && (vNext >= yStart) && (vNext < yEnd);
            oX           <= active ? xa : '0;
            oY           <= active ? ya : '0;
            oLineStart   <= (h == '0);
            oFrameStart  <= origin;
            oVGA_R       <= active ? pixR : '0;
            oVGA_G       <= active ? pixG : '0;
            oVGA_B       <= active ? pixB : '0;
            oVGA_H_SYNC  <= (h < hSyncW) ? H_POL : ~H_POL;
            oVGA_V_SYNC  <= (v < vSyncW) ? V_POL : ~V_POL;
            oVGA_BLANK_N <= active;
            if (origin) begin
                mode        <= iMODE;
                seenFrame   <= 1'b1;
                oFrameCount <= seenFrame ? oFrameCount + 16'd1 : oFrameCount;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: cycle-accurate model check of vga_timing_gen on a tiny 14x7 raster.
module tb_vga_timing_gen;
    localparam int HS = 2, HB = 3, HA = 8, HF = 1, VS = 1, VB = 1, VA = 4, VF = 1, LEAD = 2;
    localparam int HT = HS + HB + HA + HF, VT = VS + VB + VA + VF, FT = HT * VT;

    logic       iCLK = 1'b0, iRST = 1'b1;
    logic [9:0] iRed = '0, iGreen = '0, iBlue = '0;
    logic [1:0] iMODE = '0;
    logic       oRequest, oLineStart, oFrameStart, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK_N, oVGA_SYNC;
    logic [10:0] oX, oY;
    logic [15:0] oFrameCount;
    logic [9:0]  oVGA_R, oVGA_G, oVGA_B;

    vga_timing_gen #(
        .COLOR_W(10), .H_SYNC_W(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
        .V_SYNC_W(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF), .H_POL(1'b0), .V_POL(1'b0), .REQ_LEAD(LEAD)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iMODE(iMODE),
        .oRequest(oRequest), .oX(oX), .oY(oY), .oLineStart(oLineStart), .oFrameStart(oFrameStart),
        .oFrameCount(oFrameCount), .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC), .oVGA_BLANK_N(oVGA_BLANK_N), .oVGA_SYNC(oVGA_SYNC)
    );

    always #5 iCLK = ~iCLK;

    int vecs = 0, errs = 0;
    int n = 0, fcBase = 0;
    logic [1:0] modeCur = '0, modePrev = '0;
    logic reqSeen = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        vecs++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, got, exp, n, $time);
        end
    endtask

    function automatic logic [29:0] expPix(input logic [1:0] m, input int x, input int y);
        logic [2:0] c;
        c = 3'(7 - x * 8 / HA);
        case (m)
            2'd0:    return {10'(x), 10'(2 * x), 10'(3 * x)};
            2'd1:    return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
            2'd2:    return (x % 16 == 0 || y % 16 == 0) ? 30'h3FFF_FFFF : 30'h0;
            default: return 30'h0;
        endcase
    endfunction

    // n = raster position being processed in the current cycle, counted from reset release.
    always @(posedge iCLK) begin
        modePrev = modeCur;
        if (iRST) begin
            n = 0;
            modeCur = '0;
            fcBase = 0;
        end else begin
            if (n % FT == 0) modeCur = iMODE;
            n++;
        end
    end

    always @(negedge iCLK) begin
        int c, h, v, hc, vc, x, y;
        bit act;
        reqSeen = oRequest;
        if (iRST || n == 0) begin
            chk("rst_req", int'(oRequest), 0);
            chk("rst_xy", int'({oX, oY}), 0);
            chk("rst_pulses", int'({oLineStart, oFrameStart}), 0);
            chk("rst_fcount", int'(oFrameCount), 0);
            chk("rst_rgb", int'({oVGA_R, oVGA_G, oVGA_B}), 0);
            chk("rst_syncs", int'({oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK_N}), 3'b110);
        end else begin
            c = n - 1; h = c % HT; v = (c / HT) % VT;
            hc = n % HT; vc = (n / HT) % VT;
            act = h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
            x = act ? h - HS - HB : 0;
            y = act ? v - VS - VB : 0;
            chk("hsync", int'(oVGA_H_SYNC), h < HS ? 0 : 1);
            chk("vsync", int'(oVGA_V_SYNC), v < VS ? 0 : 1);
            chk("blank_n", int'(oVGA_BLANK_N), int'(act));
            chk("x", int'(oX), x);
            chk("y", int'(oY), y);
            chk("linestart", int'(oLineStart), int'(h == 0));
            chk("framestart", int'(oFrameStart), int'(h == 0 && v == 0));
            chk("fcount", int'(oFrameCount), (fcBase + c / FT) & 'hFFFF);
            chk("request", int'(oRequest), int'(hc >= HS + HB - LEAD && hc < HS + HB + HA - LEAD && vc >= VS + VB && vc < VS + VB + VA));
            chk("rgb", int'({oVGA_R, oVGA_G, oVGA_B}), act ? int'(expPix(modePrev, x, y)) : 0);
        end
        chk("csync", int'(oVGA_SYNC), 0);
    end

    // Pixel source: answers each request LEAD clocks later with its index within the line; idles at all-ones.
    initial begin
        logic [9:0] s1, idx;
        s1 = 10'h3FF; idx = '0;
        forever begin
            @(posedge iCLK);
            #1;
            iRed = s1; iGreen = 10'(2 * s1); iBlue = 10'(3 * s1);
            if (s1 == 10'h3FF) begin iGreen = 10'h3FF; iBlue = 10'h3FF; end
            s1 = reqSeen ? idx : 10'h3FF;
            idx = reqSeen ? idx + 10'd1 : '0;
        end
    end

    task automatic waitMod(input int t);
        int k;
        for (k = 0; k < 3 * FT; k++) begin
            @(negedge iCLK);
            if (n % FT == t) break;
        end
        if (k == 3 * FT) chk("timeout_pos", k, 0);
    endtask

    task automatic waitFrameStart(output int cycles);
        for (cycles = 1; cycles < 3 * FT; cycles++) begin
            @(negedge iCLK);
            if (oFrameStart) break;
        end
        if (cycles == 3 * FT) chk("timeout_framestart", cycles, 0);
    endtask

    initial begin
        int hsA, vsA, bl, rq, cyc;
        repeat (3) @(posedge iCLK);
        #2 iRST = 1'b0;

        // Periodic counts over one full frame window
        repeat (5) @(negedge iCLK);
        hsA = 0; vsA = 0; bl = 0; rq = 0;
        for (int i = 0; i < FT; i++) begin
            @(negedge iCLK);
            hsA += int'(!oVGA_H_SYNC); vsA += int'(!oVGA_V_SYNC); bl += int'(oVGA_BLANK_N); rq += int'(oRequest);
        end
        chk("hsync_per_frame", hsA, 14);
        chk("vsync_per_frame", vsA, 14);
        chk("blank_per_frame", bl, 32);
        chk("req_per_frame", rq, 32);

        // Request window on one active line (v=2)
        waitMod(2 * HT);
        rq = 0;
        for (int i = 0; i < HT; i++) begin
            if (i == 2) chk("req_h2", int'(oRequest), 0);
            if (i == 3) chk("req_h3", int'(oRequest), 1);
            if (i == 10) chk("req_h10", int'(oRequest), 1);
            if (i == 11) chk("req_h11", int'(oRequest), 0);
            rq += int'(oRequest);
            @(negedge iCLK);
        end
        chk("req_per_line", rq, 8);
        waitMod(1 * HT + 3);
        chk("req_blank_line", int'(oRequest), 0);

        // Passthrough alignment with BLANK_N
        waitMod(2 * HT + 6);
        chk("pass_first", int'({oVGA_BLANK_N, oVGA_R}), 11'h400);
        waitMod(2 * HT + 13);
        chk("pass_last", int'({oVGA_BLANK_N, oVGA_R}), 11'h407);

        // Mode change mid-frame: bars only from next frame
        waitMod(40);
        @(posedge iCLK); #2 iMODE = 2'd1;
        waitMod(3 * HT + 6);
        chk("bars_not_yet", int'(oVGA_G), 0);
        waitMod(2 * HT + 6);
        chk("bar0", int'({oVGA_R, oVGA_G, oVGA_B}), 30'h3FFF_FFFF);
        waitMod(2 * HT + 13);
        chk("bar7", int'({oVGA_R, oVGA_G, oVGA_B}), 0);

        // Grid and black modes
        @(posedge iCLK); #2 iMODE = 2'd2;
        repeat (2 * FT) @(posedge iCLK);
        #2 iMODE = 2'd3;
        repeat (2 * FT) @(posedge iCLK);
        #2 iMODE = 2'd0;

        // Reset mid-line at h=6, v=3
        waitMod(3 * HT + 6);
        #1 iRST = 1'b1;
        #1;
        chk("midrst_blank", int'(oVGA_BLANK_N), 0);
        chk("midrst_req", int'(oRequest), 0);
        chk("midrst_syncs", int'({oVGA_H_SYNC, oVGA_V_SYNC}), 2'b11);
        chk("midrst_fcount", int'(oFrameCount), 0);
        repeat (2) @(posedge iCLK);
        #2 iRST = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
        chk("restart_framestart", int'(oFrameStart), 1);
        chk("restart_fcount", int'(oFrameCount), 0);

        // Frame counter wrap
        repeat (2 * FT) @(negedge iCLK);
        waitMod(50);
        #1 force dut.oFrameCount = 16'hFFFE;
        fcBase = 'hFFFE - (n - 1) / FT;
        #1 release dut.oFrameCount;
        waitFrameStart(cyc);
        chk("wrap_ffff", int'(oFrameCount), 'hFFFF);
        waitFrameStart(cyc);
        chk("frame_period", cyc, 98);
        chk("wrap_zero", int'(oFrameCount), 0);
        waitFrameStart(cyc);
        chk("after_wrap", int'(oFrameCount), 1);

        repeat (3) @(negedge iCLK);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
